// File: rtl/axis_pattern_gen.sv
// AXI4-Lite programmed pattern generator: emits packets of incrementing 32-bit words
// on an AXI4-Stream master port, with optional back-to-back continuous packets.
module axis_pattern_gen #(
    parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH   = 4,
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                            state_q, state_d;
    logic [15:0]                       len_q;
    logic [15:0]                       remaining_q, remaining_d;
    logic [15:0]                       pkt_cnt_q, pkt_cnt_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   seed_q;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   data_q, data_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]     rdata_q, rd_mux;
    logic                              cont_q, bvalid_q, rvalid_q;

    logic       wr_fire, rd_fire, start, beat;
    logic [1:0] wr_addr, rd_addr;
    logic       unused_bits;

    assign wr_addr = S_AXI_AWADDR[3:2];
    assign rd_addr = S_AXI_ARADDR[3:2];

    // Ready strobes are combinational so the register write lands on the handshake edge.
    assign wr_fire = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~ARESET;
    assign rd_fire = S_AXI_ARVALID & ~rvalid_q & ~ARESET;
    assign start   = wr_fire && (wr_addr == 2'd0) && S_AXI_WDATA[0];
    assign beat    = (state_q == StRun) && M_AXIS_TREADY;

    assign unused_bits = ^{S_AXI_WSTRB, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        pkt_cnt_d   = pkt_cnt_q;
        case (state_q)
            StIdle: begin
                if (start && (len_q != 16'd0)) begin
                    state_d     = StRun;
                    remaining_d = len_q;
                    data_d      = seed_q;
                end
            end
            StRun: begin
                if (beat) begin
                    data_d      = data_q + 1'b1;
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                        // Continuous mode keeps counting data across packets; no reseed.
                        if (cont_q && (len_q != 16'd0)) begin
                            remaining_d = len_q;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            2'd0:    rd_mux = {30'd0, cont_q, 1'b0};
            2'd1:    rd_mux = {16'd0, len_q};
            2'd2:    rd_mux = seed_q;
            default: rd_mux = {(state_q == StRun), 15'd0, pkt_cnt_q};
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            pkt_cnt_q   <= '0;
            data_q      <= '0;
            seed_q      <= '0;
            len_q       <= '0;
            cont_q      <= 1'b0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pkt_cnt_q   <= pkt_cnt_d;
            data_q      <= data_d;

            if (wr_fire) begin
                bvalid_q <= 1'b1;
                case (wr_addr)
                    2'd0:    cont_q <= S_AXI_WDATA[1];
                    2'd1:    len_q  <= S_AXI_WDATA[15:0];
                    2'd2:    seed_q <= S_AXI_WDATA;
                    default: ;
                endcase
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end

            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = wr_fire;
    assign S_AXI_WREADY  = wr_fire;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = rd_fire;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign M_AXIS_TVALID = (state_q == StRun);
    assign M_AXIS_TDATA  = data_q;
    assign M_AXIS_TLAST  = (state_q == StRun) && (remaining_q == 16'd1);

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Self-checking bench for axis_pattern_gen: vector table, hand sequences, randomized packets
// checked against a packet-level reference model.
module tb_axis_pattern_gen;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic        M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;

    axis_pattern_gen dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] seed;
        logic [31:0] len_wr;
        int          mode;
        int          exp_cycles;
        logic [31:0] exp_last;
        logic [31:0] exp_status;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          tlast_seen = 0;
    beat_t       got_q[$];
    beat_t       exp_q[$];
    logic        hold_pending = 1'b0;
    logic [31:0] hold_data;
    logic        hold_last;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Stream monitor: records accepted beats and checks that stalled beats are held.
    always @(negedge ACLK) begin
        if (ARESET) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check1("stall_tvalid", M_AXIS_TVALID, 1'b1);
                check32("stall_tdata", M_AXIS_TDATA, hold_data);
                check1("stall_tlast", M_AXIS_TLAST, hold_last);
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                got_q.push_back('{data: M_AXIS_TDATA, last: M_AXIS_TLAST});
                if (M_AXIS_TLAST) tlast_seen++;
            end
            hold_pending = M_AXIS_TVALID && !M_AXIS_TREADY;
            hold_data    = M_AXIS_TDATA;
            hold_last    = M_AXIS_TLAST;
        end
    end

    // Reference: npkt packets of len words counting up from seed, TLAST on each packet end.
    task automatic model_packets(input logic [31:0] seed, input int len, input int npkt);
        logic [31:0] d;
        d = seed;
        exp_q.delete();
        for (int p = 0; p < npkt; p++) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back('{data: d, last: (i == len - 1)});
                d = d + 32'd1;
            end
        end
    endtask

    task automatic compare_stream(input string name);
        check32({name, "_nbeats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check32({name, "_tdata"}, got_q[i].data, exp_q[i].data);
            check1({name, "_tlast"}, got_q[i].last, exp_q[i].last);
        end
        got_q.delete();
    endtask

    // All bus tasks start and end at posedge+1.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input int bdelay);
        int n;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!S_AXI_AWREADY && n < 20);
        check1("aw_w_handshake", S_AXI_AWREADY & S_AXI_WREADY, 1'b1);
        @(posedge ACLK);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        for (int d = 0; d < bdelay; d++) begin
            @(negedge ACLK);
            check1("bvalid_held", S_AXI_BVALID, 1'b1);
            @(posedge ACLK);
            #1;
        end
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        check1("bvalid", S_AXI_BVALID, 1'b1);
        check32("bresp", {30'd0, S_AXI_BRESP}, 32'd0);
        @(posedge ACLK);
        #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input int rdelay,
                            input string name);
        int n;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!S_AXI_ARREADY && n < 20);
        check1("ar_handshake", S_AXI_ARREADY, 1'b1);
        @(posedge ACLK);
        #1;
        S_AXI_ARVALID = 1'b0;
        for (int d = 0; d < rdelay; d++) begin
            @(negedge ACLK);
            check1({name, "_rvalid_held"}, S_AXI_RVALID, 1'b1);
            check32({name, "_rdata_held"}, S_AXI_RDATA, exp);
            @(posedge ACLK);
            #1;
        end
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        check1({name, "_rvalid"}, S_AXI_RVALID, 1'b1);
        check32(name, S_AXI_RDATA, exp);
        @(posedge ACLK);
        #1;
        S_AXI_RREADY = 1'b0;
    endtask

    // Drives TREADY until TVALID has been seen and then drops; mode 0 high, 1 toggle, 2 random.
    task automatic run_stream(input int mode, output int vcyc);
        int v;
        bit started, done;
        v = 0;
        started = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge ACLK);
            if (M_AXIS_TVALID) begin
                started = 1'b1;
                v++;
            end else if (started) begin
                done = 1'b1;
            end
            if (!done) begin
                @(posedge ACLK);
                #1;
                case (mode)
                    0:       M_AXIS_TREADY = 1'b1;
                    1:       M_AXIS_TREADY = (v % 2 == 1);
                    default: M_AXIS_TREADY = 1'($urandom % 2);
                endcase
            end
        end
        @(posedge ACLK);
        #1;
        M_AXIS_TREADY = 1'b1;
        check1("stream_done", done, 1'b1);
        vcyc = v;
    endtask

    task automatic check_reset_outputs();
        check1("rst_tvalid", M_AXIS_TVALID, 1'b0);
        check1("rst_tlast", M_AXIS_TLAST, 1'b0);
        check32("rst_tdata", M_AXIS_TDATA, 32'd0);
        check1("rst_bvalid", S_AXI_BVALID, 1'b0);
        check1("rst_rvalid", S_AXI_RVALID, 1'b0);
        check32("rst_rdata", S_AXI_RDATA, 32'd0);
        check1("rst_awready", S_AXI_AWREADY, 1'b0);
        check1("rst_arready", S_AXI_ARREADY, 1'b0);
    endtask

    task automatic apply_reset();
        ARESET = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        check_reset_outputs();
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        int          vc;
        logic [31:0] last_data;
        logic [15:0] pk;
        int          n;

        vecs[0] = '{32'h0000_0001, 32'd4,          0, 4, 32'h0000_0004, 32'h0000_0001};
        vecs[1] = '{32'h0000_0001, 32'd4,          1, 8, 32'h0000_0004, 32'h0000_0002};
        vecs[2] = '{32'hFFFF_FFFE, 32'd4,          0, 4, 32'h0000_0001, 32'h0000_0003};
        vecs[3] = '{32'hABCD_0000, 32'd1,          0, 1, 32'hABCD_0000, 32'h0000_0004};
        vecs[4] = '{32'h0000_0055, 32'h0001_0005,  0, 5, 32'h0000_0059, 32'h0000_0005};

        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0; M_AXIS_TREADY = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        apply_reset();
        axi_read(4'h0, 32'd0, 0, "rst_ctrl");
        axi_read(4'h4, 32'd0, 0, "rst_len");
        axi_read(4'h8, 32'd0, 0, "rst_seed");
        axi_read(4'hC, 32'd0, 0, "rst_status");

        // Vector table: single packets under different seeds, lengths and back-pressure.
        for (int i = 0; i < 5; i++) begin
            got_q.delete();
            axi_write(4'h8, vecs[i].seed, 0);
            axi_write(4'h4, vecs[i].len_wr, 1);
            model_packets(vecs[i].seed, int'(vecs[i].len_wr[15:0]), 1);
            M_AXIS_TREADY = (vecs[i].mode == 1) ? 1'b0 : 1'b1;
            fork
                axi_write(4'h0, 32'h1, i % 3);
                run_stream(vecs[i].mode, vc);
            join
            last_data = (got_q.size() > 0) ? got_q[got_q.size() - 1].data : 32'hxxxx_xxxx;
            check32("vec_last_word", last_data, vecs[i].exp_last);
            check32("vec_valid_cycles", vc, vecs[i].exp_cycles);
            compare_stream("vec");
            axi_read(4'hC, vecs[i].exp_status, 1, "vec_status");
        end

        // Writes and START while a packet is stalled only affect the next packet.
        M_AXIS_TREADY = 1'b0;
        axi_write(4'h8, 32'h0000_0100, 0);
        axi_write(4'h4, 32'd4, 0);
        axi_write(4'h0, 32'h1, 0);
        axi_write(4'h4, 32'd2, 0);
        axi_write(4'h8, 32'h0000_0999, 0);
        axi_write(4'h0, 32'h1, 0);
        axi_read(4'hC, 32'h8000_0005, 0, "busy_status");
        @(negedge ACLK);
        check1("stalled_tvalid", M_AXIS_TVALID, 1'b1);
        check32("stalled_tdata", M_AXIS_TDATA, 32'h0000_0100);
        @(posedge ACLK);
        #1;
        model_packets(32'h0000_0100, 4, 1);
        run_stream(0, vc);
        compare_stream("start_in_run");
        model_packets(32'h0000_0999, 2, 1);
        fork
            axi_write(4'h0, 32'h1, 0);
            run_stream(0, vc);
        join
        compare_stream("next_after_run");
        axi_read(4'hC, 32'h0000_0007, 0, "status_after_two");

        // START with LEN == 0 is ignored.
        axi_write(4'h4, 32'd0, 0);
        axi_write(4'h0, 32'h1, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            check1("len0_tvalid", M_AXIS_TVALID, 1'b0);
        end
        @(posedge ACLK);
        #1;
        axi_read(4'hC, 32'h0000_0007, 0, "len0_status");

        // Continuous mode: three back-to-back packets, CONT cleared after the second TLAST.
        apply_reset();
        got_q.delete();
        axi_write(4'h8, 32'h0000_0010, 0);
        axi_write(4'h4, 32'd3, 0);
        model_packets(32'h0000_0010, 3, 3);
        M_AXIS_TREADY = 1'b1;
        tlast_seen = 0;
        fork
            begin
                axi_write(4'h0, 32'h3, 0);
                n = 0;
                while (tlast_seen < 2 && n < 100) begin
                    @(posedge ACLK);
                    #1;
                    n++;
                end
                axi_write(4'h0, 32'h0, 0);
            end
            run_stream(0, vc);
        join
        check32("cont_valid_cycles", vc, 9);
        compare_stream("cont");
        axi_read(4'hC, 32'h0000_0003, 0, "cont_status");

        // Register readback with delayed BREADY/RREADY.
        axi_write(4'h4, 32'd0, 1);
        axi_write(4'h0, 32'hFFFF_FFFF, 2);
        axi_write(4'h4, 32'hABCD_1234, 3);
        axi_write(4'h8, 32'hDEAD_BEEF, 1);
        axi_write(4'hC, 32'hFFFF_FFFF, 2);
        axi_read(4'h0, 32'h0000_0002, 2, "rb_ctrl");
        axi_read(4'h4, 32'h0000_1234, 3, "rb_len");
        axi_read(4'h8, 32'hDEAD_BEEF, 1, "rb_seed");
        axi_read(4'hC, 32'h0000_0003, 2, "rb_status");
        axi_write(4'h0, 32'h0, 0);

        // Randomized packets under random back-pressure.
        pk = 16'd3;
        for (int r = 0; r < 8; r++) begin
            logic [31:0] rseed;
            int          rlen;
            rseed = $urandom;
            rlen  = int'($urandom_range(1, 6));
            got_q.delete();
            axi_write(4'h8, rseed, int'($urandom_range(0, 2)));
            axi_write(4'h4, 32'(rlen), 0);
            model_packets(rseed, rlen, 1);
            fork
                axi_write(4'h0, 32'h1, int'($urandom_range(0, 2)));
                run_stream(2, vc);
            join
            compare_stream("rand");
            pk = pk + 16'd1;
            axi_read(4'hC, {16'd0, pk}, int'($urandom_range(0, 2)), "rand_status");
        end

        // Reset mid-packet drops the stream without a TLAST.
        axi_write(4'h8, 32'h0000_0077, 0);
        axi_write(4'h4, 32'd10, 0);
        M_AXIS_TREADY = 1'b1;
        axi_write(4'h0, 32'h1, 0);
        ARESET = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        check_reset_outputs();
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        got_q.delete();
        axi_read(4'hC, 32'd0, 0, "post_rst_status");
        axi_read(4'h8, 32'd0, 0, "post_rst_seed");
        @(negedge ACLK);
        check1("post_rst_tvalid", M_AXIS_TVALID, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
